ram_dual_arb: RTL and testbench

Arbiter sharing one synchronous dual-port RAM (two read/write ports, 1-cycle registered read, read-before-write per port) between NREQ requesters.
Each cycle it grants up to two requests, one per RAM port, in round-robin order.
It also routes the read data back one cycle later.
It sits between core/DMA/debug masters and the RAM instance.

---
 rtl/ram_dual_arb_pkg.sv | 23 ++
 rtl/ram_dual_arb_rr_pick.sv | 45 ++++
 rtl/ram_dual_arb.sv | 177 +++++++++++++++++
 tb/tb_ram_dual_arb.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_dual_arb_pkg.sv
// ram_dual_arb_pkg
//   Shared constants and helpers for the dual-port RAM arbiter:
//   - idx_width(): requester index width for a given requester count
//   - PORT0 / PORT1: RAM port numbering used to index per-port state
//   - response tag layout {valid, idx}: idx in the low bits, valid just above
package ram_dual_arb_pkg;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;
    localparam int NPORT = 2;

    // Response tag {valid, idx}: idx starts at bit 0, valid sits at bit idx_w.
    localparam int TAG_IDX_LSB = 0;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int tag_vld_pos(input int idx_w);
        return idx_w;
    endfunction

endpackage

// File: rtl/ram_dual_arb_rr_pick.sv
// ram_dual_arb_rr_pick
//   Rotating first-one finder. Scans (req & mask) starting at 'start' and
//   wrapping modulo NREQ; reports whether any bit was found and its index.
//   Ports:
//     req   [NREQ]   request vector
//     start [IDX_W]  first index to scan
//     mask  [NREQ]   eligibility mask (1 = may be picked)
//     found          at least one eligible request
//     idx   [IDX_W]  index of the first eligible request in scan order
module ram_dual_arb_rr_pick
    import ram_dual_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] start,
    input  logic [NREQ-1:0]  mask,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] rot;

    assign elig = req & mask;
    // Rotate so that bit 0 of rot corresponds to requester 'start'.
    assign rot  = NREQ'({elig, elig} >> start);

    always_comb begin
        int sum;
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = int'(start) + i;
                if (sum >= NREQ) sum = sum - NREQ;
                idx   = IDX_W'(sum);
            end
        end
    end

endmodule

// File: rtl/ram_dual_arb.sv
// ram_dual_arb
//   Shares one synchronous dual-port RAM (1-cycle registered read,
//   read-before-write) between NREQ requesters. Up to two requests are
//   granted per cycle in round-robin order: grant A drives RAM port 0,
//   grant B drives RAM port 1. Read data is routed back one cycle later.
//   Optional build macro RAM_DUAL_ARB_STAT_EN adds grant/hazard counters.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     req_i/we_i [NREQ]          request valid / write enable per requester
//     adr_i [NREQ*adr_width]     word address, requester k at slice k
//     dat_i [NREQ*dat_width]     write data, slice k
//     ack_o [NREQ]               grant this cycle (combinational)
//     resp_o [NREQ]              response valid, one cycle after ack
//     rdata_o [NREQ*dat_width]   response data, slice k
//     ram_adr*/ram_dat*/ram_we*  RAM port 0/1 address, write data, write enable
//     ram_dat0_i/ram_dat1_i      RAM port 0/1 read data
//     stat_clr_i, stat_grant_o, stat_hazard_o   (RAM_DUAL_ARB_STAT_EN only)
module ram_dual_arb
    import ram_dual_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int dat_width = 32,
    parameter int adr_width = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef RAM_DUAL_ARB_STAT_EN
    input  logic                      stat_clr_i,
    output logic [NREQ*16-1:0]        stat_grant_o,
    output logic [15:0]               stat_hazard_o,
`endif
    input  logic [NREQ-1:0]           req_i,
    input  logic [NREQ-1:0]           we_i,
    input  logic [NREQ*adr_width-1:0] adr_i,
    input  logic [NREQ*dat_width-1:0] dat_i,
    output logic [NREQ-1:0]           ack_o,
    output logic [NREQ-1:0]           resp_o,
    output logic [NREQ*dat_width-1:0] rdata_o,
    output logic [adr_width-1:0]      ram_adr0_o,
    output logic [adr_width-1:0]      ram_adr1_o,
    output logic [dat_width-1:0]      ram_dat0_o,
    output logic [dat_width-1:0]      ram_dat1_o,
    output logic                      ram_we0_o,
    output logic                      ram_we1_o,
    input  logic [dat_width-1:0]      ram_dat0_i,
    input  logic [dat_width-1:0]      ram_dat1_i
);

    localparam int IDX_W   = idx_width(NREQ);
    localparam int TAG_W   = IDX_W + 1;
    localparam int TAG_VLD = tag_vld_pos(IDX_W);

    logic [IDX_W-1:0]     rr_ptr;
    logic [TAG_W-1:0]     tag_p1 [NPORT];

    logic                 found_a, found_b;
    logic [IDX_W-1:0]     idx_a, idx_b, start_b;
    logic [NREQ-1:0]      mask_a, mask_b, hazard, onehot_a, onehot_b;
    logic [adr_width-1:0] adr_a, adr_b;
    logic [dat_width-1:0] dat_a, dat_b;
    logic                 we_a, we_b;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        if (int'(v) >= NREQ - 1) return '0;
        return v + IDX_W'(1);
    endfunction

    // Stage 0: grant selection (combinational)
    assign mask_a = '1;

    ram_dual_arb_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick_a (
        .req   (req_i),
        .start (rr_ptr),
        .mask  (mask_a),
        .found (found_a),
        .idx   (idx_a)
    );

    assign adr_a = adr_i[int'(idx_a)*adr_width +: adr_width];
    assign dat_a = dat_i[int'(idx_a)*dat_width +: dat_width];
    assign we_a  = we_i[idx_a];

    // Grant B may not reuse A's requester, nor touch A's address when either
    // side writes; read+read to the same word is harmless on a dual-port RAM.
    for (genvar k = 0; k < NREQ; k++) begin : g_mask
        assign onehot_a[k] = found_a && (idx_a == IDX_W'(k));
        assign onehot_b[k] = found_b && (idx_b == IDX_W'(k));
        assign hazard[k]   = (adr_i[k*adr_width +: adr_width] == adr_a) && (we_i[k] || we_a);
        assign mask_b[k]   = !onehot_a[k] && !hazard[k];
    end

    assign start_b = wrap_inc(idx_a);

    ram_dual_arb_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick_b (
        .req   (req_i),
        .start (start_b),
        .mask  (mask_b),
        .found (found_b),
        .idx   (idx_b)
    );

    assign adr_b = adr_i[int'(idx_b)*adr_width +: adr_width];
    assign dat_b = dat_i[int'(idx_b)*dat_width +: dat_width];
    assign we_b  = we_i[idx_b];

    assign ack_o      = rst_n ? (onehot_a | onehot_b) : '0;
    assign ram_adr0_o = found_a ? adr_a : '0;
    assign ram_dat0_o = found_a ? dat_a : '0;
    assign ram_we0_o  = rst_n && found_a && we_a;
    assign ram_adr1_o = found_b ? adr_b : '0;
    assign ram_dat1_o = found_b ? dat_b : '0;
    assign ram_we1_o  = rst_n && found_b && we_b;

    // Stage 0 -> 1: round-robin pointer and response tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            tag_p1[PORT0] <= '0;
            tag_p1[PORT1] <= '0;
        end else begin
            if (found_b)      rr_ptr <= wrap_inc(idx_b);
            else if (found_a) rr_ptr <= wrap_inc(idx_a);
            tag_p1[PORT0] <= {found_a, idx_a};
            tag_p1[PORT1] <= {found_b, idx_b};
        end
    end

    // Stage 1: route RAM read data back to the tagged requester
    always_comb begin
        logic [dat_width-1:0] rd;
        resp_o  = '0;
        rdata_o = '0;
        rd      = '0;
        for (int p = 0; p < NPORT; p++) begin
            rd = (p == PORT0) ? ram_dat0_i : ram_dat1_i;
            if (tag_p1[p][TAG_VLD]) begin
                resp_o[tag_p1[p][TAG_IDX_LSB +: IDX_W]] = 1'b1;
                rdata_o[int'(tag_p1[p][TAG_IDX_LSB +: IDX_W])*dat_width +: dat_width] = rd;
            end
        end
    end

`ifdef RAM_DUAL_ARB_STAT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] grant_cnt [NREQ];
    logic [15:0] hazard_cnt;
    logic        hazard_skip;

    // A skip is any other requesting master masked out because of A's address.
    assign hazard_skip = found_a && |(req_i & hazard & ~onehot_a);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREQ; k++) grant_cnt[k] <= '0;
            hazard_cnt <= '0;
        end else if (stat_clr_i) begin
            for (int k = 0; k < NREQ; k++) grant_cnt[k] <= '0;
            hazard_cnt <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++)
                if (onehot_a[k] || onehot_b[k]) grant_cnt[k] <= sat_inc(grant_cnt[k]);
            if (hazard_skip) hazard_cnt <= sat_inc(hazard_cnt);
        end
    end

    for (genvar k = 0; k < NREQ; k++) begin : g_stat
        assign stat_grant_o[k*16 +: 16] = grant_cnt[k];
    end
    assign stat_hazard_o = hazard_cnt;
`else
    // Statistics compiled out: no counters, no extra ports.
`endif

endmodule

// File: tb/tb_ram_dual_arb.sv
`timescale 1ns/1ps
module tb_ram_dual_arb;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [NREQ-1:0]    req, we, ack, resp;
    logic [AW-1:0]      adr [NREQ];
    logic [DW-1:0]      dat [NREQ];
    logic [NREQ*AW-1:0] adr_v;
    logic [NREQ*DW-1:0] dat_v, rdata;
    logic [AW-1:0]      ram_adr0, ram_adr1;
    logic [DW-1:0]      ram_dat0, ram_dat1, ram_q0, ram_q1;
    logic               ram_we0, ram_we1;
`ifdef RAM_DUAL_ARB_STAT_EN
    logic               stat_clr = 1'b0;
    logic [NREQ*16-1:0] stat_grant;
    logic [15:0]        stat_hazard;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        adr_v = '0;
        dat_v = '0;
        for (int k = 0; k < NREQ; k++) begin
            adr_v[k*AW +: AW] = adr[k];
            dat_v[k*DW +: DW] = dat[k];
        end
    end

    ram_dual_arb #(.NREQ(NREQ), .dat_width(DW), .adr_width(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef RAM_DUAL_ARB_STAT_EN
        .stat_clr_i    (stat_clr),
        .stat_grant_o  (stat_grant),
        .stat_hazard_o (stat_hazard),
`endif
        .req_i      (req),
        .we_i       (we),
        .adr_i      (adr_v),
        .dat_i      (dat_v),
        .ack_o      (ack),
        .resp_o     (resp),
        .rdata_o    (rdata),
        .ram_adr0_o (ram_adr0),
        .ram_adr1_o (ram_adr1),
        .ram_dat0_o (ram_dat0),
        .ram_dat1_o (ram_dat1),
        .ram_we0_o  (ram_we0),
        .ram_we1_o  (ram_we1),
        .ram_dat0_i (ram_q0),
        .ram_dat1_i (ram_q1)
    );

    // Dual-port RAM: registered read, read-before-write, plus a preload port.
    logic [DW-1:0] mem [1024];
    logic          bd_we  = 1'b0;
    logic [AW-1:0] bd_adr = '0;
    logic [DW-1:0] bd_dat = '0;

    always @(posedge clk) begin
        ram_q0 <= mem[ram_adr0];
        ram_q1 <= mem[ram_adr1];
        if (bd_we) mem[bd_adr] <= bd_dat;
        else begin
            if (ram_we0) mem[ram_adr0] <= ram_dat0;
            if (ram_we1) mem[ram_adr1] <= ram_dat1;
        end
    end

    // Reference memory and response scoreboard.
    typedef struct {
        int            k;
        logic [DW-1:0] d;
    } exp_t;

    logic [DW-1:0]   ref_mem [1024];
    exp_t            sb [$];
    logic [NREQ-1:0] exp_resp;
    logic [DW-1:0]   exp_rd [NREQ];

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_adr = a; bd_dat = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Record what each acknowledged requester must see one cycle later.
    task automatic sb_push();
        exp_t e;
        for (int k = 0; k < NREQ; k++) begin
            if (ack[k]) begin
                e.k = k;
                e.d = ref_mem[adr[k]];
                sb.push_back(e);
                if (we[k]) ref_mem[adr[k]] = dat[k];
            end
        end
    endtask

    task automatic sb_pop();
        exp_t e;
        exp_resp = '0;
        for (int k = 0; k < NREQ; k++) exp_rd[k] = '0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            exp_resp[e.k] = 1'b1;
            exp_rd[e.k]   = e.d;
        end
    endtask

    task automatic idle_inputs();
        req = '0;
        we  = '0;
        for (int k = 0; k < NREQ; k++) begin
            adr[k] = '0;
            dat[k] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '1;
        we    = '1;
        for (int k = 0; k < NREQ; k++) begin
            adr[k] = AW'(20 + k);
            dat[k] = 32'hF0F0_0000 + DW'(k);
        end
        @(negedge clk);
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset ack: got %b want 0000", ack); end
        checks++; if ({ram_we0, ram_we1} !== 2'b00) begin errors++; $display("FAIL reset ram_we: got %b want 00", {ram_we0, ram_we1}); end
        checks++; if (resp !== 4'b0000) begin errors++; $display("FAIL reset resp: got %b want 0000", resp); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL reset rdata: got %h want 0", rdata); end
        checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL reset rr_ptr: got %0d want 0", dut.rr_ptr); end
        idle_inputs();
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        req = 4'b0001; we = '0; adr[0] = 10'd5;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (ack !== (c == 0 ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL single ack c%0d: got %b want %b", c, ack, (c == 0 ? 4'b0001 : 4'b0000)); end
            if (c == 0) begin
                checks++; if (ram_we0 !== 1'b0 || ram_adr0 !== 10'd5) begin errors++; $display("FAIL single port0: got we=%b adr=%0d want we=0 adr=5", ram_we0, ram_adr0); end
            end
            sb_pop();
            checks++; if (resp !== exp_resp) begin errors++; $display("FAIL single resp c%0d: got %b want %b", c, resp, exp_resp); end
            for (int k = 0; k < NREQ; k++)
                if (exp_resp[k]) begin
                    checks++; if (rdata[k*DW +: DW] !== exp_rd[k]) begin errors++; $display("FAIL single rdata%0d: got %h want %h", k, rdata[k*DW +: DW], exp_rd[k]); end
                end
            if (c == 1) begin
                checks++; if (rdata[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single value: got %h want deadbeef", rdata[31:0]); end
            end
            sb_push();
            @(posedge clk); #1;
            req = '0;
        end
    endtask

    task automatic test_dual_grant();
        logic [NREQ-1:0] exp_ack [4] = '{4'b0011, 4'b1100, 4'b0011, 4'b0000};
        logic [1:0]      exp_rr  [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
        do_reset();
        req = 4'b1111; we = '0;
        for (int k = 0; k < NREQ; k++) adr[k] = AW'(10 + k);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) req = '0;
            @(negedge clk);
            checks++; if (ack !== exp_ack[c]) begin errors++; $display("FAIL dual ack c%0d: got %b want %b", c, ack, exp_ack[c]); end
            checks++; if (dut.rr_ptr !== exp_rr[c]) begin errors++; $display("FAIL dual rr_ptr c%0d: got %0d want %0d", c, dut.rr_ptr, exp_rr[c]); end
            sb_pop();
            checks++; if (resp !== exp_resp) begin errors++; $display("FAIL dual resp c%0d: got %b want %b", c, resp, exp_resp); end
            for (int k = 0; k < NREQ; k++)
                if (exp_resp[k]) begin
                    checks++; if (rdata[k*DW +: DW] !== exp_rd[k]) begin errors++; $display("FAIL dual rdata%0d c%0d: got %h want %h", k, c, rdata[k*DW +: DW], exp_rd[k]); end
                end
            sb_push();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write_hazard();
        logic [NREQ-1:0] exp_ack [3] = '{4'b0001, 4'b0010, 4'b0000};
        do_reset();
        req = 4'b0011; we = 4'b0001;
        adr[0] = 10'd7; dat[0] = 32'h11;
        adr[1] = 10'd7;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (ack !== exp_ack[c]) begin errors++; $display("FAIL hazard ack c%0d: got %b want %b", c, ack, exp_ack[c]); end
            if (c == 0) begin
                checks++; if (ram_we0 !== 1'b1 || ram_we1 !== 1'b0) begin errors++; $display("FAIL hazard we: got %b%b want 10", ram_we0, ram_we1); end
            end
            sb_pop();
            checks++; if (resp !== exp_resp) begin errors++; $display("FAIL hazard resp c%0d: got %b want %b", c, resp, exp_resp); end
            for (int k = 0; k < NREQ; k++)
                if (exp_resp[k]) begin
                    checks++; if (rdata[k*DW +: DW] !== exp_rd[k]) begin errors++; $display("FAIL hazard rdata%0d c%0d: got %h want %h", k, c, rdata[k*DW +: DW], exp_rd[k]); end
                end
            if (c == 2) begin
                checks++; if (rdata[DW +: DW] !== 32'h11) begin errors++; $display("FAIL hazard value: got %h want 11", rdata[DW +: DW]); end
            end
            sb_push();
            @(posedge clk); #1;
            if (c == 0) begin req[0] = 1'b0; we[0] = 1'b0; end
            if (c == 1) req = '0;
        end
    endtask

    task automatic test_read_read();
        req = 4'b1100; we = '0;
        adr[2] = 10'd3; adr[3] = 10'd3;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (ack !== (c == 0 ? 4'b1100 : 4'b0000)) begin errors++; $display("FAIL rdrd ack c%0d: got %b want %b", c, ack, (c == 0 ? 4'b1100 : 4'b0000)); end
            sb_pop();
            checks++; if (resp !== exp_resp) begin errors++; $display("FAIL rdrd resp c%0d: got %b want %b", c, resp, exp_resp); end
            for (int k = 0; k < NREQ; k++)
                if (exp_resp[k]) begin
                    checks++; if (rdata[k*DW +: DW] !== exp_rd[k]) begin errors++; $display("FAIL rdrd rdata%0d: got %h want %h", k, rdata[k*DW +: DW], exp_rd[k]); end
                end
            if (c == 1) begin
                checks++; if (rdata[2*DW +: 2*DW] !== {2{32'h3333_3333}}) begin errors++; $display("FAIL rdrd value: got %h want 3333333333333333", rdata[2*DW +: 2*DW]); end
            end
            sb_push();
            @(posedge clk); #1;
            req = '0;
        end
    endtask

    task automatic test_write_old();
        req = 4'b0010; we = 4'b0010;
        adr[1] = 10'd9; dat[1] = 32'hBB;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (ack !== (c < 2 ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL wold ack c%0d: got %b want %b", c, ack, (c < 2 ? 4'b0010 : 4'b0000)); end
            if (c == 0) begin
                checks++; if (ram_we0 !== 1'b1 || ram_dat0 !== 32'hBB) begin errors++; $display("FAIL wold port0: got we=%b dat=%h want we=1 dat=bb", ram_we0, ram_dat0); end
            end
            sb_pop();
            checks++; if (resp !== exp_resp) begin errors++; $display("FAIL wold resp c%0d: got %b want %b", c, resp, exp_resp); end
            for (int k = 0; k < NREQ; k++)
                if (exp_resp[k]) begin
                    checks++; if (rdata[k*DW +: DW] !== exp_rd[k]) begin errors++; $display("FAIL wold rdata%0d c%0d: got %h want %h", k, c, rdata[k*DW +: DW], exp_rd[k]); end
                end
            if (c >= 1) begin
                checks++; if (rdata[DW +: DW] !== (c == 1 ? 32'hAA : 32'hBB)) begin errors++; $display("FAIL wold value c%0d: got %h want %h", c, rdata[DW +: DW], (c == 1 ? 32'hAA : 32'hBB)); end
            end
            sb_push();
            @(posedge clk); #1;
            if (c == 0) we = '0;
            if (c == 1) req = '0;
        end
    endtask

    task automatic test_reset_midflight();
        req = 4'b0001; we = '0; adr[0] = 10'd5;
        @(negedge clk);
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL midrst grant: got %b want 0001", ack); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        req   = 4'b1111;
        sb.delete();
        @(negedge clk);
        checks++; if (resp !== 4'b0000) begin errors++; $display("FAIL midrst resp: got %b want 0000", resp); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL midrst ack: got %b want 0000", ack); end
        req = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (resp !== 4'b0000) begin errors++; $display("FAIL midrst resp after: got %b want 0000", resp); end
        checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL midrst rr_ptr: got %0d want 0", dut.rr_ptr); end
`ifdef RAM_DUAL_ARB_STAT_EN
        checks++; if (stat_grant !== '0 || stat_hazard !== '0) begin errors++; $display("FAIL midrst stats: got %h/%h want 0", stat_grant, stat_hazard); end
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        @(posedge clk); #1;
        preload(10'd3,  32'h3333_3333);
        preload(10'd5,  32'hDEAD_BEEF);
        preload(10'd7,  32'h77);
        preload(10'd9,  32'hAA);
        for (int i = 10; i < 14; i++) preload(AW'(i), 32'hA000_0000 + DW'(i));
        test_reset();
        test_single_read();
        test_dual_grant();
        test_write_hazard();
        test_read_read();
        test_write_old();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
